// File: rtl/exu_mc.sv
// exu_mc: handshaked execution unit (ALU, JALR, load extract, store steering) with registered results.
// Define EXU_MUL_EN to build the iterative shift-add multiplier for op 14; otherwise op 14 is illegal.
module exu_mc #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [2:0]        in_size,
  input  logic [XLEN-1:0]   in_a,
  input  logic [XLEN-1:0]   in_b,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_wdata,
  output logic [XLEN-1:0]   out_jump_pc,
  output logic [XLEN-1:0]   out_mem_wdata,
  output logic [XLEN/8-1:0] out_mem_wstrb,
  output logic              out_illegal
);

  localparam int NBYTE = XLEN / 8;
  localparam int SHW   = $clog2(XLEN);
  localparam int OFFW  = $clog2(NBYTE);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic              accept;
  logic [XLEN-1:0]   sum;
  logic [SHW-1:0]    shamt;
  logic [OFFW-1:0]   off;
  logic [XLEN-1:0]   ld_shift;
  logic [XLEN-1:0]   r_wdata;
  logic [XLEN-1:0]   r_jump;
  logic [XLEN-1:0]   r_mwdata;
  logic [NBYTE-1:0]  r_wstrb;
  logic              r_illegal;

`ifdef EXU_MUL_EN
  localparam int CNTW = SHW + 1;
  logic [XLEN-1:0]   mul_a;
  logic [XLEN-1:0]   mul_b;
  logic [XLEN-1:0]   mul_acc;
  logic [CNTW-1:0]   mul_cnt;
`endif

  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept   = in_valid & in_ready;
  assign sum      = in_a + in_b;
  assign shamt    = in_b[SHW-1:0];
  assign off      = in_a[OFFW-1:0];
  assign ld_shift = in_mem_rdata >> {off, 3'b000};

  // Single-cycle result for every op except MUL; an illegal op forces all data to zero.
  always_comb begin
    r_wdata   = '0;
    r_jump    = '0;
    r_mwdata  = '0;
    r_wstrb   = '0;
    r_illegal = 1'b0;
    case (in_op)
      4'd0:  r_wdata = sum;
      4'd1:  r_wdata = in_a - in_b;
      4'd2:  r_wdata = in_a & in_b;
      4'd3:  r_wdata = in_a | in_b;
      4'd4:  r_wdata = in_a ^ in_b;
      4'd5:  r_wdata = in_a << shamt;
      4'd6:  r_wdata = in_a >> shamt;
      4'd7:  r_wdata = XLEN'($signed(in_a) >>> shamt);
      4'd8:  r_wdata = XLEN'($signed(in_a) < $signed(in_b));
      4'd9:  r_wdata = XLEN'(in_a < in_b);
      4'd10: r_wdata = in_b;
      4'd11: begin
        r_wdata = in_pc + XLEN'(4);
        r_jump  = sum & ~XLEN'(1);
      end
      4'd12: begin
        case (in_size)
          3'b000: r_wdata = XLEN'($signed(ld_shift[7:0]));
          3'b100: r_wdata = XLEN'(ld_shift[7:0]);
          3'b001: begin
            r_wdata   = XLEN'($signed(ld_shift[15:0]));
            r_illegal = off[0];
          end
          3'b101: begin
            r_wdata   = XLEN'(ld_shift[15:0]);
            r_illegal = off[0];
          end
          3'b010: begin
            r_wdata   = XLEN'($signed(ld_shift[31:0]));
            r_illegal = (off[1:0] != 2'b00);
          end
          3'b110: begin
            r_wdata   = XLEN'(ld_shift[31:0]);
            r_illegal = (XLEN != 64) || (off[1:0] != 2'b00);
          end
          3'b011: begin
            r_wdata   = ld_shift;
            r_illegal = (XLEN != 64) || (off != '0);
          end
          default: r_illegal = 1'b1;
        endcase
      end
      4'd13: begin
        case (in_size)
          3'b000: begin
            r_mwdata = {NBYTE{in_b[7:0]}};
            r_wstrb  = NBYTE'(1) << off;
          end
          3'b001: begin
            r_mwdata  = {(NBYTE/2){in_b[15:0]}};
            r_wstrb   = NBYTE'(2'b11) << off;
            r_illegal = off[0];
          end
          3'b010: begin
            r_mwdata  = {(NBYTE/4){in_b[31:0]}};
            r_wstrb   = NBYTE'(4'hF) << off;
            r_illegal = (off[1:0] != 2'b00);
          end
          3'b011: begin
            r_mwdata  = in_b;
            r_wstrb   = '1;
            r_illegal = (XLEN != 64) || (off != '0);
          end
          default: r_illegal = 1'b1;
        endcase
      end
`ifdef EXU_MUL_EN
      4'd14: r_illegal = 1'b0;
`endif
      default: r_illegal = 1'b1;
    endcase
    if (r_illegal) begin
      r_wdata  = '0;
      r_jump   = '0;
      r_mwdata = '0;
      r_wstrb  = '0;
    end
  end

  // Control FSM with registered outputs; DONE holds the result until out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      out_valid     <= 1'b0;
      out_wdata     <= '0;
      out_jump_pc   <= '0;
      out_mem_wdata <= '0;
      out_mem_wstrb <= '0;
      out_illegal   <= 1'b0;
`ifdef EXU_MUL_EN
      mul_a         <= '0;
      mul_b         <= '0;
      mul_acc       <= '0;
      mul_cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
`ifdef EXU_MUL_EN
            if (in_op == 4'd14) begin
              state         <= BUSY;
              out_valid     <= 1'b0;
              out_wdata     <= '0;
              out_jump_pc   <= '0;
              out_mem_wdata <= '0;
              out_mem_wstrb <= '0;
              out_illegal   <= 1'b0;
              mul_a         <= in_a;
              mul_b         <= in_b;
              mul_acc       <= '0;
              mul_cnt       <= '0;
            end else
`endif
            begin
              state         <= DONE;
              out_valid     <= 1'b1;
              out_wdata     <= r_wdata;
              out_jump_pc   <= r_jump;
              out_mem_wdata <= r_mwdata;
              out_mem_wstrb <= r_wstrb;
              out_illegal   <= r_illegal;
            end
          end else if ((state == DONE) && out_ready) begin
            state         <= IDLE;
            out_valid     <= 1'b0;
            out_wdata     <= '0;
            out_jump_pc   <= '0;
            out_mem_wdata <= '0;
            out_mem_wstrb <= '0;
            out_illegal   <= 1'b0;
          end
        end
`ifdef EXU_MUL_EN
        // One multiplier bit per cycle; the extra cycle at cnt==XLEN publishes the product.
        BUSY: begin
          if (mul_cnt == CNTW'(XLEN)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_wdata <= mul_acc;
          end else begin
            if (mul_a[0]) mul_acc <= mul_acc + mul_b;
            mul_a   <= mul_a >> 1;
            mul_b   <= mul_b << 1;
            mul_cnt <= mul_cnt + 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
